// File: rtl/ntt_coef_buffer.sv
// Coefficient buffer for one NTT/INTT core: loads a polynomial from a stream, serves the
// core's two-lane read/write port, then streams the transformed result out in natural order.
module ntt_coef_buffer #(
   parameter int LOGQ       = 64,
   parameter int LOGN       = 4,
   parameter int DELAY_BRAM = 1,
   parameter int AW         = ((LOGN < 9) ? 9 : LOGN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [LOGQ-1:0] s_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [LOGQ-1:0] m_data,
   output logic            m_last,
   output logic            ntt_start,
   input  logic            ntt_finish,
   input  logic [AW-1:0]   ntt_read_address,
   output logic [LOGQ-1:0] ntt_data_in_0,
   output logic [LOGQ-1:0] ntt_data_in_1,
   input  logic [AW-1:0]   ntt_write_address,
   input  logic            ntt_wea,
   input  logic [LOGQ-1:0] ntt_data_out_0,
   input  logic [LOGQ-1:0] ntt_data_out_1,
   output logic            err
);

   localparam int HALF = (1 << LOGN) / 2;
   localparam int HW   = LOGN - 1;
   localparam logic [LOGN-1:0] K_LAST = '1;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_RUN,
      ST_UNLOAD
   } state_t;

   state_t          state_q, state_d;
   logic [LOGN-1:0] k_q, k_d;
   logic [LOGN:0]   idx_q, idx_d;
   logic            m_valid_q, m_valid_d;
   logic [LOGQ-1:0] m_data_q, m_data_d;
   logic            m_last_q, m_last_d;
   logic            err_q, err_d;
   logic [LOGQ-1:0] rd0_q, rd0_d;
   logic [LOGQ-1:0] rd1_q, rd1_d;

   logic [LOGQ-1:0] lo_mem [HALF];
   logic [LOGQ-1:0] hi_mem [HALF];

   logic            lo_we, hi_we;
   logic [HW-1:0]   lo_wa, hi_wa;
   logic [LOGQ-1:0] lo_wd, hi_wd;

   logic [HW-1:0] rd_idx, wr_idx;
   logic          rd_oob, wr_oob;

   // Only the low address bits select a word; anything above flags a protocol error.
   assign rd_idx = ntt_read_address[HW-1:0];
   assign wr_idx = ntt_write_address[HW-1:0];
   assign rd_oob = |ntt_read_address[AW-1:HW];
   assign wr_oob = |ntt_write_address[AW-1:HW];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d   = state_q;
      k_d       = k_q;
      idx_d     = idx_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      err_d     = err_q;
      lo_we     = 1'b0;
      hi_we     = 1'b0;
      lo_wa     = '0;
      hi_wa     = '0;
      lo_wd     = '0;
      hi_wd     = '0;
      rd0_d     = lo_mem[rd_idx];
      rd1_d     = hi_mem[rd_idx];

      unique case (state_q)
         ST_LOAD: begin
            if (s_valid) begin
               lo_wa = k_q[HW-1:0];
               hi_wa = k_q[HW-1:0];
               lo_wd = s_data;
               hi_wd = s_data;
               lo_we = ~k_q[HW];
               hi_we = k_q[HW];
               k_d   = k_q + 1'b1;
               if (k_q == K_LAST) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            lo_we = ntt_wea;
            hi_we = ntt_wea;
            lo_wa = wr_idx;
            hi_wa = wr_idx;
            lo_wd = ntt_data_out_0;
            hi_wd = ntt_data_out_1;
            if (rd_oob || wr_oob) err_d = 1'b1;
            if (ntt_finish) begin
               state_d = ST_UNLOAD;
               idx_d   = '0;
            end
         end
         ST_UNLOAD: begin
            // idx_q counts fetches into the output register, which runs one ahead of handshakes.
            if (m_valid_q && m_ready && m_last_q) begin
               state_d   = ST_LOAD;
               k_d       = '0;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
            end else if (!m_valid_q || m_ready) begin
               if (!idx_q[LOGN]) begin
                  m_valid_d = 1'b1;
                  m_data_d  = idx_q[HW] ? hi_mem[idx_q[HW-1:0]] : lo_mem[idx_q[HW-1:0]];
                  m_last_d  = (idx_q[LOGN-1:0] == K_LAST);
                  idx_d     = idx_q + 1'b1;
               end else begin
                  m_valid_d = 1'b0;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase

      if (state_q != ST_RUN && (ntt_wea || ntt_finish)) err_d = 1'b1;
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         k_q       <= '0;
         idx_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         err_q     <= 1'b0;
         rd0_q     <= '0;
         rd1_q     <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         idx_q     <= idx_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         err_q     <= err_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
      end
   end

   // NOTE: the banks are deliberately not reset so they map onto block RAM; the read
   // registers above sample the old word on a same-address write (read-first).
   always_ff @(posedge clk) begin
      if (lo_we) lo_mem[lo_wa] <= lo_wd;
      if (hi_we) hi_mem[hi_wa] <= hi_wd;
   end

   generate
      if (DELAY_BRAM == 2) begin : g_delay2
         logic [LOGQ-1:0] dly0_q, dly1_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               dly0_q <= '0;
               dly1_q <= '0;
            end else begin
               dly0_q <= rd0_q;
               dly1_q <= rd1_q;
            end
         end
         assign ntt_data_in_0 = dly0_q;
         assign ntt_data_in_1 = dly1_q;
      end else begin : g_delay1
         assign ntt_data_in_0 = rd0_q;
         assign ntt_data_in_1 = rd1_q;
      end
   endgenerate

   assign s_ready   = (state_q == ST_LOAD);
   assign ntt_start = (state_q == ST_RUN);
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   assign err       = err_q;

endmodule
